led_mmio_ctrl: RTL and testbench

Memory-mapped LED output controller and parametrised successor to the fixed 16-bit LED port on the FPGA top. It sits on the core's data-bus side as a peripheral. It drives NUM_LEDS outputs in one of four modes (static, blink, PWM dim, rotate), all timed by a programmable prescaler tick. A tick counter is readable for software timing checks.

---
 rtl/led_mmio_pkg.sv | 33 +++
 rtl/led_mmio_ctrl_if.sv | 32 +++
 rtl/led_prescaler.sv | 38 +++
 rtl/led_mmio_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_led_mmio_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_mmio_pkg.sv
// Shared definitions for the LED MMIO controller.
// Holds the register offsets, the LED mode encoding and the byte-strobe
// merge helper used by the register write path.
package led_mmio_pkg;

   localparam logic [4:0] OFS_OUT      = 5'h00;
   localparam logic [4:0] OFS_MODE     = 5'h04;
   localparam logic [4:0] OFS_PRESCALE = 5'h08;
   localparam logic [4:0] OFS_DUTY     = 5'h0C;
   localparam logic [4:0] OFS_TICKS    = 5'h10;

   typedef enum logic [1:0] {
      MODE_STATIC = 2'd0,
      MODE_BLINK  = 2'd1,
      MODE_PWM    = 2'd2,
      MODE_ROTATE = 2'd3
   } mode_e;

   // Replace each byte of old_val whose strobe is set with the matching byte of new_val.
   function automatic logic [31:0] merge_wstrb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) begin
            res[8*b +: 8] = new_val[8*b +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/led_mmio_ctrl_if.sv
// Data-bus interface of the LED MMIO controller.
// master: the core side, drives the request; slave: the peripheral side.
//   bus_req_i    single-cycle access request
//   bus_we_i     1 = write, 0 = read
//   bus_addr_i   byte offset within the block
//   bus_wdata_i  write data
//   bus_wstrb_i  byte write strobes
//   bus_rdata_o  registered read data, valid with bus_rvalid_o
//   bus_rvalid_o one-cycle read-data pulse
//   bus_err_o    one-cycle error pulse for a bad address
interface led_mmio_ctrl_if;

   logic        bus_req_i;
   logic        bus_we_i;
   logic [4:0]  bus_addr_i;
   logic [31:0] bus_wdata_i;
   logic [3:0]  bus_wstrb_i;
   logic [31:0] bus_rdata_o;
   logic        bus_rvalid_o;
   logic        bus_err_o;

   modport master (
      output bus_req_i, bus_we_i, bus_addr_i, bus_wdata_i, bus_wstrb_i,
      input  bus_rdata_o, bus_rvalid_o, bus_err_o
   );

   modport slave (
      input  bus_req_i, bus_we_i, bus_addr_i, bus_wdata_i, bus_wstrb_i,
      output bus_rdata_o, bus_rvalid_o, bus_err_o
   );

endinterface

// File: rtl/led_prescaler.sv
// Programmable tick prescaler.
// The counter runs 0..reload and emits a one-cycle tick while it sits at reload.
//   clk, rst  clock and asynchronous active-high reset
//   en        counting enable; low holds the counter at 0 with no ticks
//   clr       synchronous clear; also suppresses a coinciding tick
//   reload    terminal count (0 gives a tick every cycle)
//   tick      one-cycle tick pulse
module led_prescaler #(
   parameter int unsigned PRESCALE_W = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  clr,
   input  logic [PRESCALE_W-1:0] reload,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] r_pcnt;
   logic                  w_at_reload;

   always_comb begin
      w_at_reload = (r_pcnt == reload);
      tick        = en & ~clr & w_at_reload;
   end

   // ">=" rather than "==" so the counter can never run away past the reload value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pcnt <= '0;
      end else if (!en || clr || (r_pcnt >= reload)) begin
         r_pcnt <= '0;
      end else begin
         r_pcnt <= r_pcnt + PRESCALE_W'(1);
      end
   end

endmodule

// File: rtl/led_mmio_ctrl.sv
// Memory-mapped LED output controller.
// Drives NUM_LEDS outputs in static, blink, PWM or rotate mode, all paced by a
// programmable prescaler tick; a free-running tick counter is readable.
//   clk, rst  clock and asynchronous active-high reset
//   bus       register access port (slave side of led_mmio_ctrl_if)
//   leds_o    registered LED drive
module led_mmio_ctrl
   import led_mmio_pkg::*;
#(
   parameter int unsigned NUM_LEDS   = 16,
   parameter int unsigned PWM_BITS   = 8,
   parameter int unsigned PRESCALE_W = 24
) (
   input  logic                clk,
   input  logic                rst,
   led_mmio_ctrl_if.slave      bus,
   output logic [NUM_LEDS-1:0] leds_o
);

   // Register state
   logic [NUM_LEDS-1:0]   r_out;
   mode_e                 r_mode;
   logic                  r_en;
   logic [PRESCALE_W-1:0] r_prescale;
   logic [PWM_BITS-1:0]   r_duty;
   logic [31:0]           r_ticks;

   // Pattern generator state
   logic                  r_phase;
   logic [PWM_BITS-1:0]   r_pwm_cnt;
   logic [NUM_LEDS-1:0]   r_pattern;
   logic [NUM_LEDS-1:0]   r_leds;

   // Bus response
   logic [31:0]           r_rdata;
   logic                  r_rvalid;
   logic                  r_err;

   logic                  w_addr_ok;
   logic                  w_wr;
   logic                  w_rd;
   logic                  w_wr_out;
   logic                  w_wr_mode;
   logic                  w_wr_prescale;
   logic                  w_wr_duty;
   logic                  w_wr_ticks;
   logic [31:0]           w_rd_val;
   logic [31:0]           w_wr_val;
   logic [NUM_LEDS-1:0]   w_out_next;
   logic [NUM_LEDS-1:0]   w_rotated;
   logic [NUM_LEDS-1:0]   w_leds_d;
   logic                  w_tick;
   logic                  w_unused;

   // ---------------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------------
   always_comb begin
      w_addr_ok     = (bus.bus_addr_i[1:0] == 2'b00) && (bus.bus_addr_i <= OFS_TICKS);
      w_wr          = bus.bus_req_i & bus.bus_we_i & w_addr_ok;
      w_rd          = bus.bus_req_i & ~bus.bus_we_i & w_addr_ok;
      w_wr_out      = w_wr && (bus.bus_addr_i == OFS_OUT);
      w_wr_mode     = w_wr && (bus.bus_addr_i == OFS_MODE);
      w_wr_prescale = w_wr && (bus.bus_addr_i == OFS_PRESCALE);
      w_wr_duty     = w_wr && (bus.bus_addr_i == OFS_DUTY);
      w_wr_ticks    = w_wr && (bus.bus_addr_i == OFS_TICKS);
   end

   // Current value of the addressed register, zero-extended; unimplemented bits read 0.
   always_comb begin
      w_rd_val = '0;
      case (bus.bus_addr_i)
         OFS_OUT:      w_rd_val[NUM_LEDS-1:0]   = r_out;
         OFS_MODE: begin
            w_rd_val[1:0] = r_mode;
            w_rd_val[8]   = r_en;
         end
         OFS_PRESCALE: w_rd_val[PRESCALE_W-1:0] = r_prescale;
         OFS_DUTY:     w_rd_val[PWM_BITS-1:0]   = r_duty;
         OFS_TICKS:    w_rd_val                 = r_ticks;
         default:      ;
      endcase
   end

   // Strobed bytes come from the bus, the rest keep the register's current value.
   always_comb begin
      w_wr_val   = merge_wstrb(w_rd_val, bus.bus_wdata_i, bus.bus_wstrb_i);
      w_out_next = w_wr_out ? w_wr_val[NUM_LEDS-1:0] : r_out;
   end

   // Bits of the merged word that no register implements.
   assign w_unused = ^w_wr_val;

   // ---------------------------------------------------------------------------
   // Tick source; MODE and PRESCALE writes restart the count and drop a pending tick
   // ---------------------------------------------------------------------------
   led_prescaler #(
      .PRESCALE_W (PRESCALE_W)
   ) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .en     (r_en),
      .clr    (w_wr_prescale | w_wr_mode),
      .reload (r_prescale),
      .tick   (w_tick)
   );

   // ---------------------------------------------------------------------------
   // LED pattern selection
   // ---------------------------------------------------------------------------
   // Rotate left by one; the top bit wraps into bit 0 (also correct for NUM_LEDS == 1).
   assign w_rotated = (r_pattern << 1) | (r_pattern >> (NUM_LEDS - 1));

   always_comb begin
      w_leds_d = r_out;
      if (r_en) begin
         unique case (r_mode)
            MODE_STATIC: w_leds_d = r_out;
            MODE_BLINK:  w_leds_d = r_phase ? '0 : r_out;
            MODE_PWM:    w_leds_d = (r_pwm_cnt < r_duty) ? r_out : '0;
            MODE_ROTATE: w_leds_d = r_pattern;
            default:     w_leds_d = r_out;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out      <= '0;
         r_mode     <= MODE_STATIC;
         r_en       <= 1'b0;
         r_prescale <= '0;
         r_duty     <= '0;
         r_ticks    <= '0;
         r_phase    <= 1'b0;
         r_pwm_cnt  <= '0;
         r_pattern  <= '0;
         r_leds     <= '0;
         r_rdata    <= '0;
         r_rvalid   <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_out <= w_out_next;

         if (w_wr_mode) begin
            r_mode <= mode_e'(w_wr_val[1:0]);
            r_en   <= w_wr_val[8];
         end

         if (w_wr_prescale) begin
            r_prescale <= w_wr_val[PRESCALE_W-1:0];
         end

         if (w_wr_duty) begin
            r_duty <= w_wr_val[PWM_BITS-1:0];
         end

         // A clearing write beats a coinciding tick.
         if (w_wr_ticks) begin
            r_ticks <= '0;
         end else if (w_tick) begin
            r_ticks <= r_ticks + 32'd1;
         end

         if (w_wr_mode) begin
            r_phase   <= 1'b0;
            r_pwm_cnt <= '0;
         end else if (w_tick) begin
            r_phase   <= ~r_phase;
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
         end

         // Loading from OUT takes priority over a rotate step in the same cycle.
         if (w_wr_mode || w_wr_out) begin
            r_pattern <= w_out_next;
         end else if (w_tick) begin
            r_pattern <= w_rotated;
         end

         r_leds   <= w_leds_d;
         r_rvalid <= w_rd;
         r_rdata  <= w_rd ? w_rd_val : '0;
         r_err    <= bus.bus_req_i & ~w_addr_ok;
      end
   end

   assign leds_o           = r_leds;
   assign bus.bus_rdata_o  = r_rdata;
   assign bus.bus_rvalid_o = r_rvalid;
   assign bus.bus_err_o    = r_err;

endmodule

// File: tb/tb_led_mmio_ctrl.sv
module tb_led_mmio_ctrl;

   logic        clk;
   logic        rst;
   logic [15:0] leds;
   int          n_checks;
   int          n_fail;

   led_mmio_ctrl_if bus_if ();

   led_mmio_ctrl #(
      .NUM_LEDS   (16),
      .PWM_BITS   (8),
      .PRESCALE_W (24)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus_if.slave),
      .leds_o (leds)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // One bus access; commits at the next rising edge, outputs sampled 1 ns later.
   task automatic bus_access(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                             input logic [3:0] strb, output logic [31:0] rdata,
                             output logic rvalid, output logic err);
      @(negedge clk);
      bus_if.bus_req_i   = 1'b1;
      bus_if.bus_we_i    = we;
      bus_if.bus_addr_i  = addr;
      bus_if.bus_wdata_i = wdata;
      bus_if.bus_wstrb_i = strb;
      @(posedge clk);
      #1;
      rdata  = bus_if.bus_rdata_o;
      rvalid = bus_if.bus_rvalid_o;
      err    = bus_if.bus_err_o;
      bus_if.bus_req_i = 1'b0;
      bus_if.bus_we_i  = 1'b0;
   endtask

   task automatic wr(input logic [4:0] addr, input logic [31:0] data);
      logic [31:0] rd;
      logic        rv;
      logic        er;
      bus_access(1'b1, addr, data, 4'hF, rd, rv, er);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus_if.bus_req_i   = 1'b0;
      bus_if.bus_we_i    = 1'b0;
      bus_if.bus_addr_i  = '0;
      bus_if.bus_wdata_i = '0;
      bus_if.bus_wstrb_i = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      logic        rv;
      logic        er;
      do_reset();
      n_checks++;
      if (leds !== 16'h0000 || bus_if.bus_rvalid_o !== 1'b0 || bus_if.bus_err_o !== 1'b0 ||
          bus_if.bus_rdata_o !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: leds=%h rvalid=%b err=%b rdata=%h, want all 0",
                  leds, bus_if.bus_rvalid_o, bus_if.bus_err_o, bus_if.bus_rdata_o);
      end
      bus_access(1'b0, 5'h04, 32'h0, 4'h0, rd, rv, er);
      n_checks++;
      if (rd !== 32'h0 || rv !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mode_read: rdata=%h rvalid=%b, want 0 / 1", rd, rv);
      end
   endtask

   task automatic test_static();
      logic [31:0] rd;
      logic        rv;
      logic        er;
      do_reset();
      wr(5'h04, 32'h0000_0100);
      wr(5'h00, 32'h0000_A5A5);
      n_checks++;
      if (leds !== 16'h0000) begin
         n_fail++;
         $display("FAIL static_latency_early: leds=%h, want 0000", leds);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (leds !== 16'hA5A5) begin
         n_fail++;
         $display("FAIL static_latency: leds=%h, want a5a5", leds);
      end
      bus_access(1'b0, 5'h00, 32'h0, 4'h0, rd, rv, er);
      n_checks++;
      if (rd !== 32'h0000_A5A5 || rv !== 1'b1 || er !== 1'b0) begin
         n_fail++;
         $display("FAIL static_read: rdata=%h rvalid=%b err=%b, want 0000a5a5/1/0", rd, rv, er);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (bus_if.bus_rvalid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rvalid_pulse: rvalid=%b, want 0", bus_if.bus_rvalid_o);
      end
   endtask

   task automatic test_blink();
      logic [31:0] rd;
      logic        rv;
      logic        er;
      logic [15:0] exp;
      do_reset();
      wr(5'h00, 32'h0000_00FF);
      wr(5'h08, 32'd3);
      wr(5'h04, 32'h0000_0101);
      // Ticks land on edges 4, 8, ...; phase feeds leds one edge later.
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         exp = ((((k - 1) / 4) % 2) == 0) ? 16'h00FF : 16'h0000;
         n_checks++;
         if (leds !== exp) begin
            n_fail++;
            $display("FAIL blink_cycle%0d: leds=%h, want %h", k, leds, exp);
         end
      end
      bus_access(1'b0, 5'h10, 32'h0, 4'h0, rd, rv, er);
      n_checks++;
      if (rd !== 32'd10 || rv !== 1'b1) begin
         n_fail++;
         $display("FAIL blink_ticks: rdata=%0d rvalid=%b, want 10 / 1", rd, rv);
      end
   endtask

   task automatic test_pwm();
      logic [15:0] exp;
      int          ons;
      do_reset();
      wr(5'h0C, 32'd64);
      wr(5'h00, 32'h0000_FFFF);
      wr(5'h04, 32'h0000_0102);
      ons = 0;
      for (int k = 1; k <= 256; k++) begin
         @(posedge clk);
         #1;
         exp = (((k - 1) % 256) < 64) ? 16'hFFFF : 16'h0000;
         if (leds === 16'hFFFF) ons++;
         n_checks++;
         if (leds !== exp) begin
            n_fail++;
            $display("FAIL pwm_cycle%0d: leds=%h, want %h", k, leds, exp);
         end
      end
      n_checks++;
      if (ons != 64) begin
         n_fail++;
         $display("FAIL pwm_on_count: on=%0d, want 64", ons);
      end
      wr(5'h0C, 32'd0);
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (leds !== 16'h0000) begin
            n_fail++;
            $display("FAIL pwm_duty0_cycle%0d: leds=%h, want 0000", k, leds);
         end
      end
   endtask

   task automatic test_rotate();
      logic [15:0] exp;
      do_reset();
      wr(5'h00, 32'h0000_0001);
      wr(5'h04, 32'h0000_0103);
      for (int k = 1; k <= 17; k++) begin
         @(posedge clk);
         #1;
         exp = 16'h0001 << ((k - 1) % 16);
         n_checks++;
         if (leds !== exp) begin
            n_fail++;
            $display("FAIL rotate_step%0d: leds=%h, want %h", k, leds, exp);
         end
      end
      // Every cycle ticks; the OUT write must load 0003 instead of rotating 0002 to 0004.
      wr(5'h00, 32'h0000_0003);
      n_checks++;
      if (leds !== 16'h0002) begin
         n_fail++;
         $display("FAIL rotate_before_load: leds=%h, want 0002", leds);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (leds !== 16'h0003) begin
         n_fail++;
         $display("FAIL rotate_load_wins: leds=%h, want 0003", leds);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (leds !== 16'h0006) begin
         n_fail++;
         $display("FAIL rotate_after_load: leds=%h, want 0006", leds);
      end
   endtask

   task automatic test_errors_strobes();
      logic [31:0] rd;
      logic        rv;
      logic        er;
      logic [4:0]  addrs [4];
      logic [31:0] exps  [4];
      do_reset();
      wr(5'h00, 32'h0000_1234);
      wr(5'h04, 32'h0000_0002);
      wr(5'h08, 32'd5);
      wr(5'h0C, 32'h0000_0033);
      bus_access(1'b0, 5'h14, 32'h0, 4'h0, rd, rv, er);
      n_checks++;
      if (er !== 1'b1 || rv !== 1'b0 || rd !== 32'h0) begin
         n_fail++;
         $display("FAIL err_read_0x14: err=%b rvalid=%b rdata=%h, want 1/0/0", er, rv, rd);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (bus_if.bus_err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL err_pulse_width: err=%b, want 0", bus_if.bus_err_o);
      end
      bus_access(1'b1, 5'h06, 32'hFFFF_FFFF, 4'hF, rd, rv, er);
      n_checks++;
      if (er !== 1'b1 || rv !== 1'b0) begin
         n_fail++;
         $display("FAIL err_write_0x06: err=%b rvalid=%b, want 1/0", er, rv);
      end
      addrs = '{5'h00, 5'h04, 5'h08, 5'h0C};
      exps  = '{32'h0000_1234, 32'h0000_0002, 32'd5, 32'h0000_0033};
      for (int i = 0; i < 4; i++) begin
         bus_access(1'b0, addrs[i], 32'h0, 4'h0, rd, rv, er);
         n_checks++;
         if (rd !== exps[i] || rv !== 1'b1 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL err_no_change_%h: rdata=%h rvalid=%b err=%b, want %h/1/0",
                     addrs[i], rd, rv, er, exps[i]);
         end
      end
      bus_access(1'b1, 5'h04, 32'hFFFF_FFFF, 4'b0010, rd, rv, er);
      bus_access(1'b0, 5'h04, 32'h0, 4'h0, rd, rv, er);
      n_checks++;
      if (rd !== 32'h0000_0102) begin
         n_fail++;
         $display("FAIL strobe_mode_en: rdata=%h, want 00000102", rd);
      end
      bus_access(1'b1, 5'h00, 32'h0000_ABCD, 4'b0001, rd, rv, er);
      bus_access(1'b0, 5'h00, 32'h0, 4'h0, rd, rv, er);
      n_checks++;
      if (rd !== 32'h0000_12CD) begin
         n_fail++;
         $display("FAIL strobe_out_byte0: rdata=%h, want 000012cd", rd);
      end
      wr(5'h0C, 32'hFFFF_FFFF);
      bus_access(1'b0, 5'h0C, 32'h0, 4'h0, rd, rv, er);
      n_checks++;
      if (rd !== 32'h0000_00FF) begin
         n_fail++;
         $display("FAIL duty_unimpl_bits: rdata=%h, want 000000ff", rd);
      end
   endtask

   task automatic test_async_reset();
      logic [31:0] rd;
      logic        rv;
      logic        er;
      logic [4:0]  a;
      do_reset();
      wr(5'h08, 32'd0);
      wr(5'h00, 32'h0000_0001);
      wr(5'h04, 32'h0000_0103);
      repeat (5) @(posedge clk);
      #3;
      n_checks++;
      if (leds !== 16'h0010) begin
         n_fail++;
         $display("FAIL async_pre_reset: leds=%h, want 0010", leds);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (leds !== 16'h0000) begin
         n_fail++;
         $display("FAIL async_reset_leds: leds=%h, want 0000", leds);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         a = 5'(i * 4);
         bus_access(1'b0, a, 32'h0, 4'h0, rd, rv, er);
         n_checks++;
         if (rd !== 32'h0 || rv !== 1'b1 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reg_clear_%h: rdata=%h rvalid=%b err=%b, want 0/1/0",
                     a, rd, rv, er);
         end
      end
      n_checks++;
      if (leds !== 16'h0000) begin
         n_fail++;
         $display("FAIL async_leds_after: leds=%h, want 0000", leds);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      test_reset();
      test_static();
      test_blink();
      test_pwm();
      test_rotate();
      test_errors_strobes();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
